// File: rtl/matrix_operand_loader_if.sv
// Packed-matrix operand interface between the serial element source, the loader
// and the downstream arithmetic unit. master = loader view, slave = environment view.
interface matrix_operand_loader_if #(
  parameter int unsigned ELEM_W    = 8,
  parameter int unsigned MAX_ELEMS = 25
);
  localparam int unsigned BusW = ELEM_W * MAX_ELEMS;
  localparam int unsigned CntW = $clog2(MAX_ELEMS);

  logic              start;
  logic [1:0]        matrix_size;
  logic [ELEM_W-1:0] elem_in;
  logic              elem_valid;
  logic              elem_ready;
  logic [BusW-1:0]   matrix_A;
  logic [BusW-1:0]   matrix_B;
  logic [1:0]        size_out;
  logic              matrix_valid;
  logic              matrix_ack;
  logic              busy;
  logic [CntW-1:0]   elem_count;

  modport master (
    input  start, matrix_size, elem_in, elem_valid, matrix_ack,
    output elem_ready, matrix_A, matrix_B, size_out, matrix_valid, busy, elem_count
  );

  modport slave (
    output start, matrix_size, elem_in, elem_valid, matrix_ack,
    input  elem_ready, matrix_A, matrix_B, size_out, matrix_valid, busy, elem_count
  );
endinterface

// File: rtl/matrix_operand_loader.sv
// Serial loader packing matrix A then matrix B into flat operand buses, held until acked.
// Optional abort input enabled by defining MATRIX_OPERAND_LOADER_ABORT_EN.
module matrix_operand_loader #(
  parameter int unsigned ELEM_W    = 8,
  parameter int unsigned MAX_ELEMS = 25
) (
  input  logic clk,
  input  logic rst_n,
`ifdef MATRIX_OPERAND_LOADER_ABORT_EN
  input  logic abort,
`endif
  matrix_operand_loader_if.master bus
);
  localparam int unsigned BusW = ELEM_W * MAX_ELEMS;
  localparam int unsigned CntW = $clog2(MAX_ELEMS);

  typedef enum logic [1:0] {StIdle, StLoadA, StLoadB, StHold} state_e;

  state_e          state_q, state_d;
  logic [1:0]      size_q, size_d;
  logic [BusW-1:0] mat_a_q, mat_a_d;
  logic [BusW-1:0] mat_b_q, mat_b_d;
  logic            valid_q, valid_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            loading;
  logic            xfer;
  logic            last_elem;
  logic [CntW-1:0] last_idx;

  assign loading   = (state_q == StLoadA) || (state_q == StLoadB);
  assign xfer      = loading && bus.elem_valid;
  assign last_elem = (cnt_q == last_idx);

  // Elements per matrix: 4, 9, 16 or 25, packed compactly from slot 0.
  always_comb begin
    last_idx = '0;
    unique case (size_q)
      2'b00:   last_idx = CntW'(3);
      2'b01:   last_idx = CntW'(8);
      2'b10:   last_idx = CntW'(15);
      default: last_idx = CntW'(24);
    endcase
  end

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    mat_a_d = mat_a_q;
    mat_b_d = mat_b_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          size_d  = bus.matrix_size;
          mat_a_d = '0;
          mat_b_d = '0;
          cnt_d   = '0;
          state_d = StLoadA;
        end
      end
      StLoadA: begin
        if (xfer) begin
          mat_a_d[ELEM_W*cnt_q +: ELEM_W] = bus.elem_in;
          if (last_elem) begin
            cnt_d   = '0;
            state_d = StLoadB;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StLoadB: begin
        if (xfer) begin
          mat_b_d[ELEM_W*cnt_q +: ELEM_W] = bus.elem_in;
          if (last_elem) begin
            cnt_d   = '0;
            valid_d = 1'b1;
            state_d = StHold;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StHold: begin
        // Buses deliberately keep their contents after the ack.
        if (bus.matrix_ack) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef MATRIX_OPERAND_LOADER_ABORT_EN
    // Abort overrides any transfer or ack in the same cycle; size_out is kept.
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      mat_a_d = '0;
      mat_b_d = '0;
      valid_d = 1'b0;
      cnt_d   = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      size_q  <= 2'b00;
      mat_a_q <= '0;
      mat_b_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      mat_a_q <= mat_a_d;
      mat_b_q <= mat_b_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.elem_ready   = loading;
  assign bus.busy         = (state_q != StIdle);
  assign bus.matrix_A     = mat_a_q;
  assign bus.matrix_B     = mat_b_q;
  assign bus.size_out     = size_q;
  assign bus.matrix_valid = valid_q;
  assign bus.elem_count   = cnt_q;

  cnt_in_range_a: assert property (@(posedge clk) disable iff (!rst_n)
    cnt_q < CntW'(MAX_ELEMS));
  valid_only_in_hold_a: assert property (@(posedge clk) disable iff (!rst_n)
    valid_q |-> (state_q == StHold));

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Self-checking bench for matrix_operand_loader: directed and randomized loads checked
// against a packed-slot reference model built from plain element queues.
module tb_matrix_operand_loader;
  localparam int unsigned ElemW    = 8;
  localparam int unsigned MaxElems = 25;
  localparam int unsigned BusW     = ElemW * MaxElems;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matrix_operand_loader_if #(.ELEM_W(ElemW), .MAX_ELEMS(MaxElems)) bus ();

`ifdef MATRIX_OPERAND_LOADER_ABORT_EN
  logic abort = 1'b0;
`endif

  matrix_operand_loader #(.ELEM_W(ElemW), .MAX_ELEMS(MaxElems)) dut (
    .clk  (clk),
    .rst_n(rst_n),
`ifdef MATRIX_OPERAND_LOADER_ABORT_EN
    .abort(abort),
`endif
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] ea[$];
  logic [7:0] eb[$];
  int cur_n = 4;

  function automatic int n_of(input logic [1:0] s);
    return (int'(s) + 2) * (int'(s) + 2);
  endfunction

  // Reference packing: element k of the matrix lands in slot k, everything else zero.
  function automatic logic [BusW-1:0] pack(input bit sel_b);
    logic [BusW-1:0] r;
    r = '0;
    for (int k = 0; k < cur_n; k++) r[k*8 +: 8] = sel_b ? eb[k] : ea[k];
    return r;
  endfunction

  function automatic logic [7:0] elem_at(input int i);
    return (i < cur_n) ? ea[i] : eb[i - cur_n];
  endfunction

  task automatic fill_rand(input logic [1:0] sz);
    cur_n = n_of(sz);
    ea.delete();
    eb.delete();
    for (int k = 0; k < cur_n; k++) begin
      ea.push_back(8'($urandom) | 8'h01);
      eb.push_back(8'($urandom) | 8'h80);
    end
  endtask

  task automatic do_start(input logic [1:0] sz);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.matrix_size = sz;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic stream_n(input int first, input int cnt);
    for (int i = first; i < first + cnt; i++) begin
      bus.elem_valid = 1'b1;
      bus.elem_in = elem_at(i);
      @(posedge clk); #1;
    end
    bus.elem_valid = 1'b0;
  endtask

  // stall: 0 continuous, 1 valid low every 3rd cycle, 2 random gaps.
  task automatic run_load(input logic [1:0] sz, input int stall, input bit rand_ack,
                          output int lat);
    int idx;
    int cyc;
    int n;
    n = n_of(sz);
    idx = 0;
    do_start(sz);
    cyc = 1;
    while (idx < 2 * n && cyc < 1000) begin
      bus.elem_valid = !((stall == 1 && cyc % 3 == 0) || (stall == 2 && $urandom % 3 == 0));
      bus.elem_in = bus.elem_valid ? elem_at(idx) : 8'($urandom);
      bus.matrix_ack = rand_ack ? 1'($urandom) : 1'b0;
      bus.start = rand_ack ? 1'($urandom) : 1'b0;
      if (bus.elem_ready !== 1'b1) begin
        errors++; $display("FAIL load_ready idx=%0d got %b exp 1", idx, bus.elem_ready);
      end
      checks++;
      if (bus.busy !== 1'b1) begin
        errors++; $display("FAIL load_busy idx=%0d got %b exp 1", idx, bus.busy);
      end
      checks++;
      if (bus.elem_count !== 5'(idx % n)) begin
        errors++;
        $display("FAIL elem_count idx=%0d got %0d exp %0d", idx, bus.elem_count, idx % n);
      end
      checks++;
      if (bus.matrix_valid !== 1'b0) begin
        errors++; $display("FAIL early_valid idx=%0d got %b exp 0", idx, bus.matrix_valid);
      end
      checks++;
      @(posedge clk);
      if (bus.elem_valid) idx++;
      #1;
      cyc++;
    end
    bus.elem_valid = 1'b0;
    bus.matrix_ack = 1'b0;
    bus.start = 1'b0;
    lat = cyc;
    if (idx != 2 * n) begin
      errors++; $display("FAIL load_timeout got %0d transfers exp %0d", idx, 2 * n);
    end
    checks++;
    if (bus.matrix_valid !== 1'b1) begin
      errors++; $display("FAIL valid_after_load got %b exp 1", bus.matrix_valid);
    end
    checks++;
    if (bus.elem_ready !== 1'b0) begin
      errors++; $display("FAIL hold_ready got %b exp 0", bus.elem_ready);
    end
    checks++;
    if (bus.matrix_A !== pack(1'b0)) begin
      errors++; $display("FAIL matrix_A got %h exp %h", bus.matrix_A, pack(1'b0));
    end
    checks++;
    if (bus.matrix_B !== pack(1'b1)) begin
      errors++; $display("FAIL matrix_B got %h exp %h", bus.matrix_B, pack(1'b1));
    end
    checks++;
    if (bus.size_out !== sz) begin
      errors++; $display("FAIL size_out got %b exp %b", bus.size_out, sz);
    end
    checks++;
  endtask

  task automatic ack_hold();
    bus.matrix_ack = 1'b1;
    @(posedge clk); #1;
    bus.matrix_ack = 1'b0;
    if (bus.matrix_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL ack_exit got valid=%b busy=%b exp 0 0", bus.matrix_valid, bus.busy);
    end
    checks++;
  endtask

  task automatic test_reset();
    #12;
    if ({bus.matrix_valid, bus.elem_ready, bus.busy, bus.elem_count, bus.size_out} !== '0
        || bus.matrix_A !== '0 || bus.matrix_B !== '0) begin
      errors++;
      $display("FAIL reset_state got v=%b r=%b b=%b c=%0d s=%b exp all 0",
               bus.matrix_valid, bus.elem_ready, bus.busy, bus.elem_count, bus.size_out);
    end
    checks++;
    @(negedge clk) rst_n = 1'b1;
    fill_rand(2'b01);
    do_start(2'b01);
    stream_n(0, cur_n + 3);
    if (bus.elem_count !== 5'd3 || bus.matrix_A !== pack(1'b0)) begin
      errors++; $display("FAIL mid_load_b got count=%0d exp 3", bus.elem_count);
    end
    checks++;
    #2 rst_n = 1'b0;
    #1;
    if ({bus.matrix_valid, bus.elem_ready, bus.busy, bus.elem_count, bus.size_out} !== '0
        || bus.matrix_A !== '0 || bus.matrix_B !== '0) begin
      errors++;
      $display("FAIL async_reset got r=%b b=%b c=%0d s=%b exp all 0",
               bus.elem_ready, bus.busy, bus.elem_count, bus.size_out);
    end
    checks++;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle got busy=%b exp 0", bus.busy);
    end
    checks++;
  endtask

  task automatic test_2x2();
    int lat;
    cur_n = 4;
    ea = '{8'd1, 8'd2, 8'd3, 8'd4};
    eb = '{8'hFF, 8'd5, 8'd6, 8'd7};
    run_load(2'b00, 0, 1'b0, lat);
    if (lat != 9) begin
      errors++; $display("FAIL latency_2x2 got %0d exp 9", lat);
    end
    checks++;
    if (bus.matrix_A[31:0] !== 32'h04030201 || bus.matrix_B[31:0] !== 32'h070605FF) begin
      errors++;
      $display("FAIL pack_2x2 got %h %h exp 04030201 070605ff",
               bus.matrix_A[31:0], bus.matrix_B[31:0]);
    end
    checks++;
    if (bus.matrix_A[BusW-1:32] !== '0 || bus.matrix_B[BusW-1:32] !== '0) begin
      errors++; $display("FAIL upper_zero_2x2 got nonzero exp 0");
    end
    checks++;
    ack_hold();
  endtask

  task automatic test_5x5_stall();
    int lat;
    cur_n = 25;
    ea.delete();
    eb.delete();
    for (int k = 0; k < 25; k++) begin
      ea.push_back(8'(k));
      eb.push_back(8'(100 + k));
    end
    run_load(2'b11, 1, 1'b0, lat);
    if (bus.matrix_A[24*8 +: 8] !== 8'd24 || bus.matrix_B[24*8 +: 8] !== 8'd124) begin
      errors++;
      $display("FAIL slot24 got %0d %0d exp 24 124", bus.matrix_A[24*8 +: 8],
               bus.matrix_B[24*8 +: 8]);
    end
    checks++;
    ack_hold();
  endtask

  task automatic test_hold_ack();
    int lat;
    logic [BusW-1:0] ha;
    logic [BusW-1:0] hb;
    fill_rand(2'b10);
    run_load(2'b10, 0, 1'b0, lat);
    ha = pack(1'b0);
    hb = pack(1'b1);
    for (int c = 0; c < 20; c++) begin
      bus.start = 1'($urandom);
      bus.matrix_size = 2'($urandom);
      bus.elem_valid = 1'($urandom);
      bus.elem_in = 8'($urandom);
      @(posedge clk); #1;
      if (bus.matrix_A !== ha || bus.matrix_B !== hb || bus.size_out !== 2'b10
          || bus.matrix_valid !== 1'b1 || bus.elem_ready !== 1'b0 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL hold_stable c=%0d got v=%b r=%b b=%b s=%b exp 1 0 1 10", c,
                 bus.matrix_valid, bus.elem_ready, bus.busy, bus.size_out);
      end
      checks++;
    end
    bus.elem_valid = 1'b0;
    bus.start = 1'b1;
    ack_hold();
    bus.start = 1'b0;
    if (bus.matrix_A !== ha || bus.matrix_B !== hb) begin
      errors++; $display("FAIL buses_after_ack got %h exp %h", bus.matrix_A, ha);
    end
    checks++;
    @(posedge clk); #1;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL ack_beats_start got busy=%b exp 0", bus.busy);
    end
    checks++;
  endtask

  task automatic test_reload();
    int lat;
    fill_rand(2'b11);
    run_load(2'b11, 0, 1'b0, lat);
    ack_hold();
    fill_rand(2'b01);
    run_load(2'b01, 0, 1'b0, lat);
    if (bus.matrix_A[BusW-1:72] !== '0 || bus.matrix_B[BusW-1:72] !== '0) begin
      errors++;
      $display("FAIL stale_slots got %h exp 0", bus.matrix_A[BusW-1:72]);
    end
    checks++;
    ack_hold();
  endtask

  task automatic test_random();
    int lat;
    logic [1:0] sz;
    for (int it = 0; it < 8; it++) begin
      sz = 2'($urandom);
      fill_rand(sz);
      run_load(sz, int'($urandom_range(0, 2)), 1'b1, lat);
      ack_hold();
    end
  endtask

`ifdef MATRIX_OPERAND_LOADER_ABORT_EN
  task automatic test_abort();
    int lat;
    logic [BusW-1:0] ha;
    fill_rand(2'b01);
    do_start(2'b01);
    stream_n(0, cur_n + 2);
    bus.elem_valid = 1'b1;
    bus.elem_in = 8'h5A;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    bus.elem_valid = 1'b0;
    if (bus.busy !== 1'b0 || bus.matrix_A !== '0 || bus.matrix_B !== '0
        || bus.elem_count !== 5'd0 || bus.size_out !== 2'b01) begin
      errors++;
      $display("FAIL abort_state got busy=%b cnt=%0d s=%b exp 0 0 01",
               bus.busy, bus.elem_count, bus.size_out);
    end
    checks++;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (bus.matrix_valid !== 1'b0 || bus.busy !== 1'b0) begin
        errors++; $display("FAIL abort_no_valid got %b exp 0", bus.matrix_valid);
      end
      checks++;
    end
    cur_n = 4;
    ea = '{8'd1, 8'd2, 8'd3, 8'd4};
    eb = '{8'hFF, 8'd5, 8'd6, 8'd7};
    run_load(2'b00, 0, 1'b0, lat);
    ack_hold();
    ha = pack(1'b0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    if (bus.matrix_A !== ha || bus.busy !== 1'b0) begin
      errors++; $display("FAIL abort_idle got %h exp %h", bus.matrix_A, ha);
    end
    checks++;
  endtask
`endif

  initial begin
    bus.start = 1'b0;
    bus.matrix_size = 2'b00;
    bus.elem_in = 8'h00;
    bus.elem_valid = 1'b0;
    bus.matrix_ack = 1'b0;
    test_reset();
    test_2x2();
    test_5x5_stall();
    test_hold_ack();
    test_reload();
    test_random();
`ifdef MATRIX_OPERAND_LOADER_ABORT_EN
    test_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
